sd_card_cmd_responder: RTL and testbench
========================================

# sd_card_cmd_responder

Card-side endpoint of the SD CMD line, used as the device model behind the host controller in system benches and FPGA loopback builds. It deserialises 48-bit host command frames, checks framing and CRC7, and presents index and argument to card logic. It then serialises R1/R3 (48-bit) or R2 (136-bit) responses back onto CMD within the NCR turnaround window.

## Interface
- NCR_MIN, 2, minimum bit periods between the command end bit and the response start bit
- NCR_MAX, 64, bit periods after the command end bit before an unanswered window closes
- ex_clk  in  1  sole clock; one clock for the whole block
- reset  in  1  synchronous, active-high reset
- bit_en  in  1  one-cycle strobe per SD bit period; all line sampling and driving happens only on cycles with bit_en=1
- sd_cmd_in  in  1  CMD line as seen by the card
- sd_cmd_out  out  1  card drive value; 1 when not transmitting
- sd_cmd_oe  out  1  card output enable
- cmd_valid  out  1  one-cycle pulse: complete command frame received
- cmd_index  out  6  command index, held until the next frame
- cmd_arg  out  32  command argument, held until the next frame
- cmd_crc_err  out  1  CRC7 mismatch on the frame, qualified by cmd_valid
- cmd_frame_err  out  1  transmission bit or end bit wrong, qualified by cmd_valid
- rsp_valid  in  1  card logic offers a response
- rsp_ready  out  1  response window open
- rsp_long  in  1  1: R2 (136-bit); 0: 48-bit
- rsp_no_crc  in  1  48-bit only: send 7'h7F instead of CRC7 (R3)
- rsp_data  in  128  short: [37:0] = index,arg; long: [127:1] = CID/CSD payload including its CRC7
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, RX_CMD, WAIT_RSP, TX_RSP.
- IDLE: on bit_en with sd_cmd_in=0 (start bit), go to RX_CMD with bit count 1.
- RX_CMD: shift in 47 more bits, MSB first.
  - Frame layout: transmission bit (expected 1), index[5:0], arg[31:0], crc[6:0], end bit (expected 1).
  - On the end bit: update cmd_index/cmd_arg, pulse cmd_valid, set error flags, then go to WAIT_RSP with turnaround counter 0.
- CRC7: polynomial x^7+x^3+1, initial value 0, computed over the first 40 frame bits (start through argument). The same generator is used for transmit.
- WAIT_RSP:
  - rsp_ready=1 until a response is accepted (rsp_valid & rsp_ready); on acceptance rsp_data, rsp_long and rsp_no_crc are latched into the shift register.
  - The counter increments on every bit_en.
  - Transmission starts on the first bit_en where the counter is at least NCR_MIN and a response is latched.
  - If the counter reaches NCR_MAX with nothing accepted, return to IDLE. This is the no-response case, e.g. CMD0.
  - If a start bit is sampled before acceptance, abandon the window and enter RX_CMD. After acceptance, sd_cmd_in is ignored.
- TX_RSP frames:
  - 48-bit: 0, 0, rsp_data[37:0], CRC7 (or 7'h7F when rsp_no_crc), 1.
  - R2: 0, 0, 6'b111111, rsp_data[127:1], 1. No CRC is generated; the payload carries its own CRC7.
  - After the end bit, deassert sd_cmd_oe and return to IDLE.
- sd_cmd_in is ignored throughout TX_RSP.

## Timing
- Reset values: sd_cmd_out=1, sd_cmd_oe=0, cmd_valid=0, cmd_index=0, cmd_arg=0, cmd_crc_err=0, cmd_frame_err=0, rsp_ready=0, busy=0, state=IDLE.
- Reset takes effect at the next ex_clk edge from any state. A response in progress is truncated, and the line returns to 1 with oe=0 on that edge.
- All outputs are registered.
- cmd_valid is high for exactly one ex_clk cycle, the cycle after the bit_en that sampled the end bit. rsp_ready rises in that same cycle.
- sd_cmd_out and sd_cmd_oe change only on the edge ending a bit_en cycle. Each driven bit is held for one full bit period.
- Gap between the end-bit sample and the start-bit drive is at least NCR_MIN bit periods. If rsp_valid is already high when rsp_ready rises, the gap is exactly NCR_MIN.
- rsp_ready falls the cycle after acceptance.
- bit_en held low indefinitely freezes all line activity. It does not freeze the handshake.

## Configuration
- SD_CARD_CMD_CRC_CHECK_EN defined: a frame with CRC mismatch still pulses cmd_valid with cmd_crc_err=1, but no response window opens. The state goes directly to IDLE and rsp_ready stays 0.
- SD_CARD_CMD_CRC_CHECK_EN undefined: received CRC is not checked, cmd_crc_err is constant 0, and every frame opens a window. The transmit CRC generator is always present.

## Test plan
- CMD0 frame 48'h40_0000_0000_95, no rsp_valid -> cmd_valid pulse, index=0, arg=0, both errs 0; rsp_ready drops and busy=0 after 64 bit periods.
- CMD8 frame 48'h48_0000_01AA_87, rsp_valid with rsp_data[37:0]={6'd8,32'h1AA} offered immediately -> start bit exactly 2 bit periods after the end bit; 48 bits driven with CRC7 equal to the golden model; end bit 1; oe low afterwards.
- CMD17 frame with the CRC byte corrupted to 0x54 -> cmd_crc_err=1; with the macro defined, rsp_ready is never asserted; without it, the window opens and cmd_crc_err=0.
- R3 response with rsp_no_crc=1, arg 32'h80FF8000 -> final byte on the wire 8'hFF; R2 with rsp_long=1 -> exactly 136 bits, bits 2..7 all 1.
- Reset asserted at bit 70 of an R2 transmission -> next cycle sd_cmd_out=1, oe=0, busy=0; a following CMD0 frame is decoded normally.
- Start bit injected at WAIT_RSP counter=5 with no response accepted -> new frame decoded, previous window abandoned.

Source files
------------

// File: rtl/sd_card_cmd_responder_if.sv
// Card-logic side of the SD CMD responder: decoded command out, response in.
// master = card logic (offers responses), slave = responder endpoint.
interface sd_card_cmd_responder_if;
  logic         cmd_valid;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic         cmd_crc_err;
  logic         cmd_frame_err;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_long;
  logic         rsp_no_crc;
  logic [127:0] rsp_data;

  modport master (
    input  cmd_valid, cmd_index, cmd_arg,
    input  cmd_crc_err, cmd_frame_err, rsp_ready,
    output rsp_valid, rsp_long, rsp_no_crc, rsp_data
  );

  modport slave (
    output cmd_valid, cmd_index, cmd_arg,
    output cmd_crc_err, cmd_frame_err, rsp_ready,
    input  rsp_valid, rsp_long, rsp_no_crc, rsp_data
  );
endinterface

// File: rtl/sd_card_cmd_responder.sv
// SD card CMD-line endpoint: receives 48-bit commands, sends R1/R3/R2.
// Ports: ex_clk, reset (sync, high), bit_en strobe, sd_cmd_in/out/oe, busy,
// card (slave modport): cmd_* decode outputs, rsp_* response handshake.
// Macro SD_CARD_CMD_CRC_CHECK_EN: a bad command CRC suppresses the window.
module sd_card_cmd_responder #(
  parameter int NCR_MIN = 2,
  parameter int NCR_MAX = 64
) (
  input  logic ex_clk,
  input  logic reset,
  input  logic bit_en,
  input  logic sd_cmd_in,
  output logic sd_cmd_out,
  output logic sd_cmd_oe,
  output logic busy,
  sd_card_cmd_responder_if.slave card
);

  localparam int NW = $clog2(NCR_MAX + 1);

  typedef enum logic [1:0] {
    IDLE, RX_CMD, WAIT_RSP, TX_RSP
  } state_t;

  state_t        r_state;
  logic [5:0]    r_rx_cnt;
  logic [46:0]   r_rx;
  logic [NW-1:0] r_ncr;
  logic          r_have;
  logic [135:0]  r_tx;
  logic          r_tx_long;
  logic [7:0]    r_tx_cnt;
  logic          r_out;
  logic          r_oe;
  logic          r_busy;
  logic          r_cmd_valid;
  logic [5:0]    r_cmd_index;
  logic [31:0]   r_cmd_arg;
  logic          r_crc_err;
  logic          r_frame_err;
  logic          r_rsp_ready;

  // Serial CRC7, x^7+x^3+1, zero seed, MSB first.
  function automatic logic [6:0] f_crc7(
    input logic [39:0] d
  );
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  logic [47:0]   w_frame;
  logic          w_crc_bad;
  logic          w_frm_bad;
  logic          w_accept;
  logic [6:0]    w_tx_crc;
  logic [135:0]  w_tx_load;
  logic [7:0]    w_tx_last;
  logic [NW-1:0] w_ncr_nxt;
  logic          w_unused;

  assign w_frame   = {r_rx, sd_cmd_in};
  assign w_crc_bad = f_crc7(w_frame[47:8]) != w_frame[7:1];
  assign w_frm_bad = !w_frame[46] || !w_frame[0];
  assign w_accept  = r_rsp_ready & card.rsp_valid;
  assign w_ncr_nxt = r_ncr + NW'(1);
  assign w_tx_last = r_tx_long ? 8'd136 : 8'd48;
  assign w_unused  = card.rsp_data[0];

  assign w_tx_crc = card.rsp_no_crc ? 7'h7F :
    f_crc7({2'b00, card.rsp_data[37:0]});

  // Frames are left-aligned so bit 135 is always the next bit out.
  assign w_tx_load = card.rsp_long ?
    {2'b00, 6'h3F, card.rsp_data[127:1], 1'b1} :
    {2'b00, card.rsp_data[37:0], w_tx_crc,
     1'b1, 88'h0};

  always_ff @(posedge ex_clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rx_cnt    <= '0;
      r_rx        <= '0;
      r_ncr       <= '0;
      r_have      <= 1'b0;
      r_tx        <= '0;
      r_tx_long   <= 1'b0;
      r_tx_cnt    <= '0;
      r_out       <= 1'b1;
      r_oe        <= 1'b0;
      r_busy      <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_cmd_index <= '0;
      r_cmd_arg   <= '0;
      r_crc_err   <= 1'b0;
      r_frame_err <= 1'b0;
      r_rsp_ready <= 1'b0;
    end else begin
      r_cmd_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bit_en && !sd_cmd_in) begin
            r_state  <= RX_CMD;
            r_busy   <= 1'b1;
            r_rx_cnt <= 6'd1;
            r_rx     <= '0;
          end
        end
        RX_CMD: begin
          if (bit_en) begin
            if (r_rx_cnt == 6'd47) begin
              r_cmd_index <= w_frame[45:40];
              r_cmd_arg   <= w_frame[39:8];
              r_cmd_valid <= 1'b1;
              r_frame_err <= w_frm_bad;
              r_ncr       <= '0;
              r_have      <= 1'b0;
`ifdef SD_CARD_CMD_CRC_CHECK_EN
              r_crc_err   <= w_crc_bad;
              if (w_crc_bad) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_state     <= WAIT_RSP;
                r_rsp_ready <= 1'b1;
              end
`else
              r_crc_err   <= 1'b0;
              r_state     <= WAIT_RSP;
              r_rsp_ready <= 1'b1;
`endif
            end else begin
              r_rx     <= {r_rx[45:0], sd_cmd_in};
              r_rx_cnt <= r_rx_cnt + 6'd1;
            end
          end
        end
        WAIT_RSP: begin
          if (w_accept) begin
            r_rsp_ready <= 1'b0;
            r_have      <= 1'b1;
            r_tx        <= w_tx_load;
            r_tx_long   <= card.rsp_long;
          end
          if (bit_en) begin
            r_ncr <= w_ncr_nxt;
            if (r_have && w_ncr_nxt >= NW'(NCR_MIN)) begin
              r_state  <= TX_RSP;
              r_out    <= r_tx[135];
              r_oe     <= 1'b1;
              r_tx     <= {r_tx[134:0], 1'b0};
              r_tx_cnt <= 8'd1;
            end else if (!r_have && !w_accept) begin
              // A new command wins over a still-open window.
              if (!sd_cmd_in) begin
                r_state     <= RX_CMD;
                r_rx_cnt    <= 6'd1;
                r_rx        <= '0;
                r_rsp_ready <= 1'b0;
              end else if (w_ncr_nxt == NW'(NCR_MAX)) begin
                r_state     <= IDLE;
                r_busy      <= 1'b0;
                r_rsp_ready <= 1'b0;
              end
            end
          end
        end
        TX_RSP: begin
          if (bit_en) begin
            if (r_tx_cnt == w_tx_last) begin
              r_out   <= 1'b1;
              r_oe    <= 1'b0;
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_out    <= r_tx[135];
              r_tx     <= {r_tx[134:0], 1'b0};
              r_tx_cnt <= r_tx_cnt + 8'd1;
            end
          end
        end
      endcase
    end
  end

  assign sd_cmd_out         = r_out;
  assign sd_cmd_oe          = r_oe;
  assign busy               = r_busy;
  assign card.cmd_valid     = r_cmd_valid;
  assign card.cmd_index     = r_cmd_index;
  assign card.cmd_arg       = r_cmd_arg;
  assign card.cmd_crc_err   = r_crc_err;
  assign card.cmd_frame_err = r_frame_err;
  assign card.rsp_ready     = r_rsp_ready;

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Bench for sd_card_cmd_responder: host-side driver and line monitor
// with a division-based CRC7 reference model.
`timescale 1ns/1ps
module tb_sd_card_cmd_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       bit_en = 1'b0;
  logic       bit_en_on;
  logic [1:0] div = 2'd0;
  logic       sd_cmd_in;
  logic       sd_cmd_out;
  logic       sd_cmd_oe;
  logic       busy;
  int         n_cmp;
  int         n_bad;

  sd_card_cmd_responder_if card_if();

  sd_card_cmd_responder dut (
    .ex_clk     (clk),
    .reset      (reset),
    .bit_en     (bit_en),
    .sd_cmd_in  (sd_cmd_in),
    .sd_cmd_out (sd_cmd_out),
    .sd_cmd_oe  (sd_cmd_oe),
    .busy       (busy),
    .card       (card_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    div    <= div + 2'd1;
    bit_en <= bit_en_on && (div == 2'd3);
  end

  // Remainder of M(x)*x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] m_crc7(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] m_cmd(
    input logic [5:0] idx, input logic [31:0] arg,
    input logic tb, input logic eb);
    logic [39:0] m;
    m = {1'b0, tb, idx, arg};
    return {m, m_crc7(m), eb};
  endfunction

  function automatic logic [135:0] m_short(
    input logic [37:0] d, input logic no_crc);
    logic [6:0] c;
    c = no_crc ? 7'h7F : m_crc7({2'b00, d});
    return {88'h0, 2'b00, d, c, 1'b1};
  endfunction

  function automatic logic [135:0] m_long(input logic [127:0] d);
    return {2'b00, 6'h3F, d[127:1], 1'b1};
  endfunction

  task automatic tick();
    logic be;
    be = 1'b0;
    while (!be) begin
      @(negedge clk);
      be = bit_en;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      sd_cmd_in = f[i];
      tick();
    end
    sd_cmd_in = 1'b1;
  endtask

  // Monitors the line per bit period; drops rsp_valid on handshake.
  task automatic collect(
    input int offer_at, input int stop_at,
    output int gap, output int nb,
    output logic [135:0] bits, output logic tmo);
    int   t;
    logic be, acc, seen;
    t = 0; nb = 0; gap = -1; bits = '0;
    seen = 1'b0; tmo = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      be  = bit_en;
      acc = card_if.rsp_valid & card_if.rsp_ready;
      @(posedge clk);
      #1;
      if (acc) card_if.rsp_valid = 1'b0;
      if (be) begin
        t++;
        if (sd_cmd_oe) begin
          if (!seen) gap = t;
          seen = 1'b1;
          bits = {bits[134:0], sd_cmd_out};
          nb++;
          if (stop_at != 0 && nb == stop_at) begin
            tmo = 1'b0;
            break;
          end
        end else if (seen) begin
          tmo = 1'b0;
          break;
        end
        if (t == offer_at) card_if.rsp_valid = 1'b1;
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({sd_cmd_out, sd_cmd_oe, busy} !== 3'b100) begin
      n_bad++;
      $display("FAIL reset_line: got %b want 100",
               {sd_cmd_out, sd_cmd_oe, busy});
    end
    n_cmp++;
    if ({card_if.cmd_valid, card_if.cmd_crc_err,
         card_if.cmd_frame_err, card_if.rsp_ready} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 0000",
               {card_if.cmd_valid, card_if.cmd_crc_err,
                card_if.cmd_frame_err, card_if.rsp_ready});
    end
    n_cmp++;
    if ({card_if.cmd_index, card_if.cmd_arg} !== 38'h0) begin
      n_bad++;
      $display("FAIL reset_cmd: got %h want 0",
               {card_if.cmd_index, card_if.cmd_arg});
    end
    reset = 1'b0;
  endtask

  task automatic test_cmd0();
    send_frame(48'h40_0000_0000_95);
    n_cmp++;
    if ({card_if.cmd_valid, card_if.cmd_crc_err,
         card_if.cmd_frame_err, card_if.rsp_ready} !== 4'b1001) begin
      n_bad++;
      $display("FAIL cmd0_flags: got %b want 1001",
               {card_if.cmd_valid, card_if.cmd_crc_err,
                card_if.cmd_frame_err, card_if.rsp_ready});
    end
    n_cmp++;
    if ({card_if.cmd_index, card_if.cmd_arg} !== 38'h0) begin
      n_bad++;
      $display("FAIL cmd0_decode: got %h want 0",
               {card_if.cmd_index, card_if.cmd_arg});
    end
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (i == 63) begin
        n_cmp++;
        if (busy !== 1'b1) begin
          n_bad++;
          $display("FAIL cmd0_busy63: got %b want 1", busy);
        end
      end
    end
    n_cmp++;
    if ({busy, card_if.rsp_ready, sd_cmd_oe} !== 3'b000) begin
      n_bad++;
      $display("FAIL cmd0_timeout: got %b want 000",
               {busy, card_if.rsp_ready, sd_cmd_oe});
    end
  endtask

  task automatic test_cmd8();
    int gap, nb;
    logic [135:0] bits;
    logic tmo;
    card_if.rsp_long   = 1'b0;
    card_if.rsp_no_crc = 1'b0;
    card_if.rsp_data   = {90'h0, 6'd8, 32'h1AA};
    card_if.rsp_valid  = 1'b1;
    send_frame(48'h48_0000_01AA_87);
    n_cmp++;
    if ({card_if.cmd_valid, card_if.cmd_crc_err, card_if.cmd_frame_err,
         card_if.rsp_ready, card_if.cmd_index, card_if.cmd_arg}
        !== {4'b1001, 6'd8, 32'h1AA}) begin
      n_bad++;
      $display("FAIL cmd8_decode: got %h want %h",
               {card_if.cmd_valid, card_if.cmd_crc_err,
                card_if.cmd_frame_err, card_if.rsp_ready,
                card_if.cmd_index, card_if.cmd_arg},
               {4'b1001, 6'd8, 32'h1AA});
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({card_if.cmd_valid, card_if.rsp_ready} !== 2'b00) begin
      n_bad++;
      $display("FAIL cmd8_pulse_ready: got %b want 00",
               {card_if.cmd_valid, card_if.rsp_ready});
    end
    card_if.rsp_valid = 1'b0;
    collect(0, 0, gap, nb, bits, tmo);
    n_cmp++;
    if ({tmo, gap, nb} !== {1'b0, 32'd2, 32'd48}) begin
      n_bad++;
      $display("FAIL cmd8_timing: tmo %b gap %0d bits %0d want 0/2/48",
               tmo, gap, nb);
    end
    n_cmp++;
    if (bits !== m_short({6'd8, 32'h1AA}, 1'b0)) begin
      n_bad++;
      $display("FAIL cmd8_bits: got %h want %h",
               bits, m_short({6'd8, 32'h1AA}, 1'b0));
    end
    n_cmp++;
    if ({sd_cmd_oe, sd_cmd_out, busy} !== 3'b010) begin
      n_bad++;
      $display("FAIL cmd8_release: got %b want 010",
               {sd_cmd_oe, sd_cmd_out, busy});
    end
  endtask

  task automatic test_crc_err();
    logic [47:0] f;
    logic [6:0]  bad;
    logic        any_rdy;
    f   = m_cmd(6'd17, 32'h0000_0200, 1'b1, 1'b1);
    bad = 7'h54 ^ {6'b0, f[7:1] == 7'h54};
    f[7:1] = bad;
    send_frame(f);
    n_cmp++;
    if ({card_if.cmd_valid, card_if.cmd_index} !== {1'b1, 6'd17}) begin
      n_bad++;
      $display("FAIL crc_valid: got %h want %h",
               {card_if.cmd_valid, card_if.cmd_index}, {1'b1, 6'd17});
    end
`ifdef SD_CARD_CMD_CRC_CHECK_EN
    n_cmp++;
    if ({card_if.cmd_crc_err, card_if.rsp_ready} !== 2'b10) begin
      n_bad++;
      $display("FAIL crc_err_on: got %b want 10",
               {card_if.cmd_crc_err, card_if.rsp_ready});
    end
    any_rdy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      any_rdy = any_rdy | card_if.rsp_ready;
    end
    n_cmp++;
    if ({any_rdy, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL crc_no_window: got %b want 00", {any_rdy, busy});
    end
`else
    any_rdy = card_if.rsp_ready;
    n_cmp++;
    if ({card_if.cmd_crc_err, any_rdy} !== 2'b01) begin
      n_bad++;
      $display("FAIL crc_err_off: got %b want 01",
               {card_if.cmd_crc_err, any_rdy});
    end
    wait_idle();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL crc_window_close: got %b want 0", busy);
    end
`endif
  endtask

  task automatic test_r3();
    int gap, nb;
    logic [135:0] bits;
    logic tmo;
    card_if.rsp_long   = 1'b0;
    card_if.rsp_no_crc = 1'b1;
    card_if.rsp_data   = {90'h0, 6'h3F, 32'h80FF_8000};
    card_if.rsp_valid  = 1'b1;
    send_frame(m_cmd(6'd41, $urandom, 1'b1, 1'b1));
    collect(0, 0, gap, nb, bits, tmo);
    n_cmp++;
    if ({tmo, nb} !== {1'b0, 32'd48}) begin
      n_bad++;
      $display("FAIL r3_len: tmo %b bits %0d want 0/48", tmo, nb);
    end
    n_cmp++;
    if (bits[7:0] !== 8'hFF) begin
      n_bad++;
      $display("FAIL r3_last_byte: got %h want ff", bits[7:0]);
    end
    n_cmp++;
    if (bits !== m_short({6'h3F, 32'h80FF_8000}, 1'b1)) begin
      n_bad++;
      $display("FAIL r3_bits: got %h want %h",
               bits, m_short({6'h3F, 32'h80FF_8000}, 1'b1));
    end
    card_if.rsp_no_crc = 1'b0;
  endtask

  task automatic test_r2();
    int gap, nb;
    logic [135:0] bits;
    logic [127:0] d;
    logic tmo;
    d = {$urandom, $urandom, $urandom, $urandom};
    card_if.rsp_long  = 1'b1;
    card_if.rsp_data  = d;
    card_if.rsp_valid = 1'b1;
    send_frame(m_cmd(6'd2, 32'h0, 1'b1, 1'b1));
    collect(0, 0, gap, nb, bits, tmo);
    n_cmp++;
    if ({tmo, gap, nb} !== {1'b0, 32'd2, 32'd136}) begin
      n_bad++;
      $display("FAIL r2_len: tmo %b gap %0d bits %0d want 0/2/136",
               tmo, gap, nb);
    end
    n_cmp++;
    if (bits[133:128] !== 6'h3F) begin
      n_bad++;
      $display("FAIL r2_reserved: got %h want 3f", bits[133:128]);
    end
    n_cmp++;
    if (bits !== m_long(d)) begin
      n_bad++;
      $display("FAIL r2_bits: got %h want %h", bits, m_long(d));
    end
    card_if.rsp_long = 1'b0;
  endtask

  task automatic test_reset_mid();
    int gap, nb;
    logic [135:0] bits;
    logic tmo;
    card_if.rsp_long  = 1'b1;
    card_if.rsp_data  = {$urandom, $urandom, $urandom, $urandom};
    card_if.rsp_valid = 1'b1;
    send_frame(m_cmd(6'd9, 32'h1234_0000, 1'b1, 1'b1));
    collect(0, 70, gap, nb, bits, tmo);
    n_cmp++;
    if ({tmo, nb, sd_cmd_oe} !== {1'b0, 32'd70, 1'b1}) begin
      n_bad++;
      $display("FAIL rstmid_reach: tmo %b bits %0d oe %b want 0/70/1",
               tmo, nb, sd_cmd_oe);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({sd_cmd_out, sd_cmd_oe, busy} !== 3'b100) begin
      n_bad++;
      $display("FAIL rstmid_line: got %b want 100",
               {sd_cmd_out, sd_cmd_oe, busy});
    end
    reset = 1'b0;
    card_if.rsp_valid = 1'b0;
    card_if.rsp_long  = 1'b0;
    send_frame(48'h40_0000_0000_95);
    n_cmp++;
    if ({card_if.cmd_valid, card_if.cmd_frame_err, card_if.cmd_crc_err,
         card_if.cmd_index, card_if.cmd_arg} !== {3'b100, 38'h0}) begin
      n_bad++;
      $display("FAIL rstmid_cmd0: got %h want %h",
               {card_if.cmd_valid, card_if.cmd_frame_err,
                card_if.cmd_crc_err, card_if.cmd_index,
                card_if.cmd_arg}, {3'b100, 38'h0});
    end
    wait_idle();
  endtask

  task automatic test_abandon();
    logic [31:0] arg;
    arg = $urandom;
    send_frame(m_cmd(6'd55, $urandom, 1'b1, 1'b1));
    repeat (5) tick();
    send_frame(m_cmd(6'd13, arg, 1'b1, 1'b1));
    n_cmp++;
    if ({card_if.cmd_valid, card_if.cmd_index, card_if.cmd_arg,
         card_if.rsp_ready} !== {1'b1, 6'd13, arg, 1'b1}) begin
      n_bad++;
      $display("FAIL abandon_decode: got %h want %h",
               {card_if.cmd_valid, card_if.cmd_index,
                card_if.cmd_arg, card_if.rsp_ready},
               {1'b1, 6'd13, arg, 1'b1});
    end
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (i == 63) begin
        n_cmp++;
        if (busy !== 1'b1) begin
          n_bad++;
          $display("FAIL abandon_busy63: got %b want 1", busy);
        end
      end
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL abandon_close: got %b want 0", busy);
    end
  endtask

  task automatic test_freeze();
    int gap, nb;
    logic [135:0] bits;
    logic [37:0]  d;
    logic tmo;
    d = {6'd7, $urandom};
    card_if.rsp_data = {90'h0, d};
    send_frame(m_cmd(6'd7, d[31:0], 1'b1, 1'b1));
    bit_en_on = 1'b0;
    card_if.rsp_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({card_if.rsp_ready, sd_cmd_oe} !== 2'b00) begin
      n_bad++;
      $display("FAIL freeze_accept: got %b want 00",
               {card_if.rsp_ready, sd_cmd_oe});
    end
    card_if.rsp_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    n_cmp++;
    if ({sd_cmd_oe, sd_cmd_out, busy} !== 3'b011) begin
      n_bad++;
      $display("FAIL freeze_line: got %b want 011",
               {sd_cmd_oe, sd_cmd_out, busy});
    end
    bit_en_on = 1'b1;
    collect(0, 0, gap, nb, bits, tmo);
    n_cmp++;
    if ({tmo, gap, nb} !== {1'b0, 32'd2, 32'd48}
        || bits !== m_short(d, 1'b0)) begin
      n_bad++;
      $display("FAIL freeze_rsp: gap %0d bits %0d data %h want 2/48/%h",
               gap, nb, bits, m_short(d, 1'b0));
    end
  endtask

  task automatic test_random();
    int gap, nb, offer, kind, ferr, egap;
    logic [135:0] bits, exp;
    logic [127:0] d;
    logic [5:0]   idx;
    logic [31:0]  arg;
    logic tmo, tb, eb;
    for (int it = 0; it < 10; it++) begin
      idx   = 6'($urandom_range(0, 63));
      arg   = $urandom;
      ferr  = $urandom_range(0, 3);
      kind  = $urandom_range(0, 2);
      offer = $urandom_range(0, 20);
      d     = {$urandom, $urandom, $urandom, $urandom};
      tb    = (ferr != 1);
      eb    = (ferr != 2);
      card_if.rsp_long   = (kind == 2);
      card_if.rsp_no_crc = (kind == 1);
      card_if.rsp_data   = d;
      exp  = (kind == 2) ? m_long(d) : m_short(d[37:0], kind == 1);
      egap = (offer + 1 > 2) ? offer + 1 : 2;
      card_if.rsp_valid = (offer == 0);
      send_frame(m_cmd(idx, arg, tb, eb));
      n_cmp++;
      if ({card_if.cmd_valid, card_if.cmd_crc_err,
           card_if.cmd_frame_err, card_if.cmd_index, card_if.cmd_arg}
          !== {2'b10, !(tb && eb), idx, arg}) begin
        n_bad++;
        $display("FAIL rand_decode[%0d]: got %h want %h", it,
                 {card_if.cmd_valid, card_if.cmd_crc_err,
                  card_if.cmd_frame_err, card_if.cmd_index,
                  card_if.cmd_arg}, {2'b10, !(tb && eb), idx, arg});
      end
      collect(offer, 0, gap, nb, bits, tmo);
      n_cmp++;
      if ({tmo, gap, nb} !== {1'b0, egap, (kind == 2) ? 32'd136 : 32'd48}
          || bits !== exp) begin
        n_bad++;
        $display("FAIL rand_rsp[%0d]: gap %0d/%0d bits %0d data %h want %h",
                 it, gap, egap, nb, bits, exp);
      end
    end
    card_if.rsp_long   = 1'b0;
    card_if.rsp_no_crc = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    sd_cmd_in = 1'b1;
    bit_en_on = 1'b1;
    card_if.rsp_valid  = 1'b0;
    card_if.rsp_long   = 1'b0;
    card_if.rsp_no_crc = 1'b0;
    card_if.rsp_data   = '0;
    test_reset();
    test_cmd0();
    test_cmd8();
    test_crc_err();
    test_r3();
    test_r2();
    test_reset_mid();
    test_abandon();
    test_freeze();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
